// File: rtl/bus_master_arbiter.sv
// Two-master round-robin arbiter for the 32-bit IO bus with ownership-held
// four-phase transactions and a watchdog that aborts unanswered transactions.
module bus_master_arbiter #(
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    ADDR_WIDTH     = 8,
   parameter int                    TIMEOUT_CYCLES = 1024,
   parameter logic [DATA_WIDTH-1:0] FAULT_DATA     = 32'hDEADBEEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  m0_req,
   output logic                  m0_grant,
   input  logic                  m0_handshake_1,
   input  logic                  m0_RW,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_handshake_2,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic                  m0_timeout,
   input  logic                  m1_req,
   output logic                  m1_grant,
   input  logic                  m1_handshake_1,
   input  logic                  m1_RW,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_handshake_2,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  m1_timeout,
   output logic                  bus_handshake_1,
   output logic                  bus_RW,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   input  logic                  bus_handshake_2,
   input  logic [DATA_WIDTH-1:0] bus_rdata,
   output logic [7:0]            timeout_count
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_OWN      = 3'd1;
   localparam logic [2:0] S_ACTIVE   = 3'd2;
   localparam logic [2:0] S_COMPLETE = 3'd3;
   localparam logic [2:0] S_FAULT    = 3'd4;

   localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [2:0]            r_state;
   logic                  r_owner;
   logic                  r_last_owner;
   logic                  r_grant0;
   logic                  r_grant1;
   logic [15:0]           r_wdog;
   logic [DATA_WIDTH-1:0] r_rdata0;
   logic [DATA_WIDTH-1:0] r_rdata1;
   logic                  r_timeout0;
   logic                  r_timeout1;
   logic [7:0]            r_timeout_count;

   logic                  w_own_req;
   logic                  w_own_hs1;
   logic                  w_own_rw;
   logic [ADDR_WIDTH-1:0] w_own_addr;
   logic [DATA_WIDTH-1:0] w_own_wdata;
   logic                  w_own_hs2;
   logic                  w_winner;

   assign w_own_req   = r_owner ? m1_req         : m0_req;
   assign w_own_hs1   = r_owner ? m1_handshake_1 : m0_handshake_1;
   assign w_own_rw    = r_owner ? m1_RW          : m0_RW;
   assign w_own_addr  = r_owner ? m1_addr        : m0_addr;
   assign w_own_wdata = r_owner ? m1_wdata       : m0_wdata;

   // Contention goes to whichever master did not own the bus last.
   assign w_winner = (m0_req && m1_req) ? ~r_last_owner : ~m0_req;

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      bus_handshake_1 = 1'b0;
      bus_RW          = 1'b0;
      bus_addr        = '0;
      bus_wdata       = '0;
      w_own_hs2       = 1'b0;
      if (r_state != S_IDLE) begin
         bus_RW    = w_own_rw;
         bus_addr  = w_own_addr;
         bus_wdata = w_own_wdata;
      end
      case (r_state)
         S_OWN, S_ACTIVE: bus_handshake_1 = w_own_hs1;
         S_COMPLETE: begin
            bus_handshake_1 = w_own_hs1;
            w_own_hs2       = bus_handshake_2;
         end
         S_FAULT:    w_own_hs2 = 1'b1;
         default:    ;
      endcase
   end

   assign m0_handshake_2 = w_own_hs2 & ~r_owner;
   assign m1_handshake_2 = w_own_hs2 &  r_owner;
   assign m0_grant       = r_grant0;
   assign m1_grant       = r_grant1;
   assign m0_rdata       = r_rdata0;
   assign m1_rdata       = r_rdata1;
   assign m0_timeout     = r_timeout0;
   assign m1_timeout     = r_timeout1;
   assign timeout_count  = r_timeout_count;

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state         <= S_IDLE;
         r_owner         <= 1'b0;
         r_last_owner    <= 1'b1;
         r_grant0        <= 1'b0;
         r_grant1        <= 1'b0;
         r_wdog          <= '0;
         r_rdata0        <= '0;
         r_rdata1        <= '0;
         r_timeout0      <= 1'b0;
         r_timeout1      <= 1'b0;
         r_timeout_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (m0_req || m1_req) begin
                  r_owner  <= w_winner;
                  r_grant0 <= ~w_winner;
                  r_grant1 <= w_winner;
                  r_state  <= S_OWN;
               end
            end
            S_OWN: begin
               if (w_own_hs1) begin
                  r_wdog  <= '0;
                  r_state <= S_ACTIVE;
               end else if (!w_own_req) begin
                  r_grant0     <= 1'b0;
                  r_grant1     <= 1'b0;
                  r_last_owner <= r_owner;
                  r_state      <= S_IDLE;
               end
            end
            S_ACTIVE: begin
               r_wdog <= r_wdog + 16'd1;
               if (bus_handshake_2) begin
                  if (r_owner) begin
                     if (w_own_rw) r_rdata1 <= bus_rdata;
                     r_timeout1 <= 1'b0;
                  end else begin
                     if (w_own_rw) r_rdata0 <= bus_rdata;
                     r_timeout0 <= 1'b0;
                  end
                  r_state <= S_COMPLETE;
               end else if (!w_own_hs1) begin
                  r_state <= S_OWN;
               end else if (r_wdog == WDOG_LAST) begin
                  if (r_owner) begin
                     r_rdata1   <= FAULT_DATA;
                     r_timeout1 <= 1'b1;
                  end else begin
                     r_rdata0   <= FAULT_DATA;
                     r_timeout0 <= 1'b1;
                  end
                  if (r_timeout_count != 8'hFF) r_timeout_count <= r_timeout_count + 8'd1;
                  r_state <= S_FAULT;
               end
            end
            S_COMPLETE: begin
               if (!w_own_hs1 && !bus_handshake_2) r_state <= S_OWN;
            end
            S_FAULT: begin
               // A late slave handshake_2 here is deliberately ignored.
               if (!w_own_hs1) r_state <= S_OWN;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Self-checking bench for bus_master_arbiter: directed scenarios followed by
// randomized transactions checked against a transaction-level reference model.
module tb_bus_master_arbiter;

   localparam int          DW = 32;
   localparam int          AW = 8;
   localparam int          TO = 16;
   localparam logic [31:0] FD = 32'hDEADBEEF;

   logic                 clk   = 1'b0;
   logic                 reset = 1'b0;
   logic [1:0]           req   = '0;
   logic [1:0]           hs1   = '0;
   logic [1:0]           rw    = '0;
   logic [1:0][AW-1:0]   addr  = '0;
   logic [1:0][DW-1:0]   wdata = '0;
   wire  [1:0]           grant;
   wire  [1:0]           hs2;
   wire  [1:0]           tmo;
   wire  [1:0][DW-1:0]   rdata;
   wire                  bus_hs1;
   wire                  bus_rw;
   wire  [AW-1:0]        bus_addr;
   wire  [DW-1:0]        bus_wdata;
   logic                 bus_hs2   = 1'b0;
   logic [DW-1:0]        bus_rdata = '0;
   wire  [7:0]           tcount;

   // Transaction-level reference state
   int                   last_owner;
   logic [1:0][31:0]     m_rdata;
   logic [1:0]           m_tmo;
   int                   m_count;

   int                   n_checks = 0;
   int                   n_pass   = 0;

   always #5 clk = ~clk;

   bus_master_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .FAULT_DATA(FD)
   ) dut (
      .clk(clk), .reset(reset),
      .m0_req(req[0]), .m0_grant(grant[0]), .m0_handshake_1(hs1[0]), .m0_RW(rw[0]),
      .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_handshake_2(hs2[0]),
      .m0_rdata(rdata[0]), .m0_timeout(tmo[0]),
      .m1_req(req[1]), .m1_grant(grant[1]), .m1_handshake_1(hs1[1]), .m1_RW(rw[1]),
      .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_handshake_2(hs2[1]),
      .m1_rdata(rdata[1]), .m1_timeout(tmo[1]),
      .bus_handshake_1(bus_hs1), .bus_RW(bus_rw), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_handshake_2(bus_hs2), .bus_rdata(bus_rdata),
      .timeout_count(tcount)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [1:0] onehot(input int m);
      return (m == 1) ? 2'b10 : 2'b01;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic model_reset();
      last_owner = 1;
      m_rdata    = '0;
      m_tmo      = '0;
      m_count    = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " grant"},   grant,     0);
      check({tag, " hs2"},     hs2,       0);
      check({tag, " bus_hs1"}, bus_hs1,   0);
      check({tag, " bus_rw"},  bus_rw,    0);
      check({tag, " bus_addr"}, bus_addr, 0);
      check({tag, " bus_wdata"}, bus_wdata, 0);
      check({tag, " rdata0"},  rdata[0],  0);
      check({tag, " rdata1"},  rdata[1],  0);
      check({tag, " tmo"},     tmo,       0);
      check({tag, " tcount"},  tcount,    0);
   endtask

   task automatic do_reset();
      tick();
      reset = 1'b0; req = '0; hs1 = '0; bus_hs2 = 1'b0;
      #1 check_all_zero("reset");
      tick();
      reset = 1'b1;
      model_reset();
      tick();
   endtask

   // Raise requests in IDLE and check the round-robin winner one edge later.
   task automatic arbitrate(input logic [1:0] r, output int winner);
      req = r;
      if (r == 2'b11) winner = 1 - last_owner;
      else            winner = r[0] ? 0 : 1;
      tick();
      check("grant after req", grant, onehot(winner));
   endtask

   // One four-phase transaction by granted master m; the bench also plays the slave.
   task automatic txn(input int m, input logic is_read, input logic [7:0] a,
                      input logic [31:0] d, input logic [31:0] sd, input int lat,
                      input logic respond, input logic drop_req, input logic noise);
      int o;
      o = 1 - m;
      rw[m] = is_read; addr[m] = a; wdata[m] = d; hs1[m] = 1'b1;
      #1 check("own bus_hs1", bus_hs1, 1);
      tick();
      if (drop_req) req[m] = 1'b0;
      if (respond) begin
         for (int c = 1; c <= lat; c++) begin
            check("active bus_addr", bus_addr, a);
            check("active bus_wdata", bus_wdata, d);
            check("active bus_rw", bus_rw, is_read);
            check("active bus_hs1", bus_hs1, 1);
            check("active hs2", hs2, 0);
            check("active grant", grant, onehot(m));
            if (noise) begin
               hs1[o] = 1'($urandom); rw[o] = 1'($urandom);
               addr[o] = 8'($urandom); wdata[o] = $urandom;
            end
            if (c == lat) begin
               bus_hs2 = 1'b1; bus_rdata = sd;
            end
            tick();
         end
         if (is_read) m_rdata[m] = sd;
         m_tmo[m] = 1'b0;
         check("complete hs2", hs2, onehot(m));
         check("complete rdata owner", rdata[m], m_rdata[m]);
         check("complete rdata other", rdata[o], m_rdata[o]);
         check("complete tmo", tmo, m_tmo);
         hs1[m] = 1'b0; hs1[o] = 1'b0;
         tick();
         check("complete hold hs2", hs2, onehot(m));
         check("complete bus_hs1 low", bus_hs1, 0);
         bus_hs2 = 1'b0;
         #1 check("complete hs2 echo low", hs2, 0);
         tick();
      end else begin
         for (int c = 1; c <= TO; c++) begin
            check("wait hs2", hs2, 0);
            check("wait bus_hs1", bus_hs1, 1);
            if (noise) begin
               hs1[o] = 1'($urandom); addr[o] = 8'($urandom);
            end
            tick();
         end
         m_rdata[m] = FD;
         m_tmo[m]   = 1'b1;
         if (m_count < 255) m_count++;
         check("fault hs2", hs2, onehot(m));
         check("fault bus_hs1", bus_hs1, 0);
         check("fault rdata", rdata[m], FD);
         check("fault tmo", tmo, m_tmo);
         check("fault tcount", tcount, m_count);
         bus_hs2 = 1'b1; bus_rdata = $urandom;
         tick();
         check("late hs2 rdata", rdata[m], FD);
         check("late hs2 held", hs2, onehot(m));
         bus_hs2 = 1'b0;
         hs1[m] = 1'b0; hs1[o] = 1'b0;
         tick();
      end
      check("back in own hs2", hs2, 0);
      check("back in own grant", grant, onehot(m));
   endtask

   task automatic release_bus(input int m);
      req[m] = 1'b0;
      tick();
      last_owner = m;
      check("release grant", grant, 0);
   endtask

   initial begin
      int w;
      logic [1:0] r;
      logic rd, resp, drop;
      model_reset();

      // Reset values and single write by m0
      do_reset();
      check_all_zero("post reset");
      arbitrate(2'b01, w);
      txn(0, 1'b0, 8'h10, 32'h12345678, '0, 5, 1'b1, 1'b0, 1'b0);
      release_bus(0);

      // Contention from reset, hand-over, then the next contention
      do_reset();
      arbitrate(2'b11, w);
      check("first winner", w, 0);
      txn(0, 1'b0, 8'h20, 32'h0000_0001, '0, 2, 1'b1, 1'b0, 1'b0);
      release_bus(0);
      tick();
      check("handover grant", grant, 2'b10);
      txn(1, 1'b1, 8'h30, 32'h0, 32'hCAFEF00D, 3, 1'b1, 1'b0, 1'b0);
      check("m1 read data", rdata[1], 32'hCAFEF00D);
      check("m0 rdata untouched", rdata[0], 32'h0);
      release_bus(1);
      arbitrate(2'b11, w);
      check("second contention winner", w, 0);
      txn(0, 1'b1, 8'h31, 32'h0, 32'h0BAD_F00D, 1, 1'b1, 1'b0, 1'b0);
      release_bus(0);
      req = '0;
      tick();

      // Timeout, then a successful transaction clears the flag
      arbitrate(2'b01, w);
      txn(0, 1'b1, 8'hEE, 32'h0, '0, 0, 1'b0, 1'b0, 1'b0);
      release_bus(0);
      arbitrate(2'b01, w);
      txn(0, 1'b0, 8'h11, 32'hA5A5_5A5A, '0, 4, 1'b1, 1'b0, 1'b0);
      check("timeout cleared", tmo[0], 0);
      check("rdata kept after write", rdata[0], FD);
      release_bus(0);

      // Non-owner noise and req dropped mid-ACTIVE
      arbitrate(2'b01, w);
      txn(0, 1'b0, 8'h42, 32'h1357_9BDF, '0, 6, 1'b1, 1'b1, 1'b1);
      release_bus(0);

      // Asynchronous reset during ACTIVE
      arbitrate(2'b01, w);
      hs1[0] = 1'b1; addr[0] = 8'h55; wdata[0] = 32'h7777_7777; rw[0] = 1'b0;
      tick();
      tick();
      #2 reset = 1'b0;
      #1 check_all_zero("async reset");
      hs1 = '0; req = '0;
      tick();
      reset = 1'b1;
      model_reset();
      tick();
      arbitrate(2'b01, w);
      txn(0, 1'b1, 8'h56, 32'h0, 32'h2468_ACE0, 2, 1'b1, 1'b0, 1'b0);
      release_bus(0);

      // timeout_count saturation
      for (int k = 0; k < 258; k++) begin
         arbitrate(2'b10, w);
         txn(1, 1'b0, 8'hFF, 32'h0, '0, 0, 1'b0, 1'b0, 1'b0);
         release_bus(1);
      end
      check("tcount saturated", tcount, 255);

      // Randomized traffic against the model
      for (int n = 0; n < 60; n++) begin
         r = 2'($urandom_range(1, 3));
         arbitrate(r, w);
         for (int k = 0; k < 2; k++) begin
            rd   = 1'($urandom);
            resp = ($urandom_range(0, 4) != 0);
            drop = 1'($urandom);
            txn(w, rd, 8'($urandom), $urandom, $urandom, $urandom_range(1, 10),
                resp, drop, 1'b1);
            release_bus(w);
            if (req == 2'b00) break;
            w = 1 - w;
            tick();
            check("random handover grant", grant, onehot(w));
         end
      end
      check("final tmo", tmo, m_tmo);
      check("final tcount", tcount, m_count);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
